// File: rtl/seq_game_core_if.sv
// Player-side bundle of the Simon-style game engine: controls and buttons in,
// note display, status, score and debug taps out.
interface seq_game_core_if #(
   parameter int N_BTN   = 7,
   parameter int MAX_SEQ = 16,
   parameter int SCORE_W = 8
);
   localparam int IDX_W = $clog2(N_BTN);
   localparam int CNT_W = $clog2(MAX_SEQ);

   logic               jogar;
   logic               treinamento;
   logic [N_BTN-1:0]   botoes;
   logic [N_BTN-1:0]   leds;
   logic               pronto;
   logic               acertou;
   logic               errou;
   logic               nota_valida;
   logic [IDX_W-1:0]   nota_idx;
   logic [SCORE_W-1:0] pontos;
   logic [2:0]         vidas;
   logic [4:0]         db_estado;
   logic [CNT_W-1:0]   db_limite;
   logic [CNT_W-1:0]   db_contagem;
   logic               db_timeout;

   modport master (
      output jogar, treinamento, botoes,
      input  leds, pronto, acertou, errou, nota_valida, nota_idx, pontos, vidas,
             db_estado, db_limite, db_contagem, db_timeout
   );

   modport slave (
      input  jogar, treinamento, botoes,
      output leds, pronto, acertou, errou, nota_valida, nota_idx, pontos, vidas,
             db_estado, db_limite, db_contagem, db_timeout
   );
endinterface

// File: rtl/seq_game_core.sv
// Simon-style game engine: replays an LFSR note sequence, checks presses,
// keeps score and lives, with a training mode that never ends in defeat.
module seq_game_core #(
   parameter int N_BTN       = 7,
   parameter int MAX_SEQ     = 16,
   parameter int SHOW_CYC    = 50,
   parameter int GAP_CYC     = 25,
   parameter int TIMEOUT_CYC = 5000,
   parameter int LIVES       = 3,
   parameter int SCORE_W     = 8,
   parameter int HIT_PTS     = 1,
   parameter int ROUND_PTS   = 5
) (
   input logic            clock,
   input logic            reset,
   seq_game_core_if.slave gif
);
   localparam int IDX_W = $clog2(N_BTN);
   localparam int CNT_W = $clog2(MAX_SEQ);
   localparam int TIM_W = $clog2(TIMEOUT_CYC + SHOW_CYC + GAP_CYC + 1);

   typedef enum logic [4:0] {
      INICIAL     = 5'd0,
      PREPARA     = 5'd1,
      MOSTRA      = 5'd2,
      INTERVALO   = 5'd3,
      ESPERA      = 5'd4,
      PROXIMA     = 5'd5,
      ERRO_RODADA = 5'd6,
      FIM_ACERTO  = 5'd7,
      FIM_ERRO    = 5'd8
   } state_t;

   function automatic logic [15:0] lfsr_step(input logic [15:0] v);
      lfsr_step = {1'b0, v[15:1]} ^ (v[0] ? 16'hB400 : 16'h0000);
   endfunction

   function automatic logic [IDX_W-1:0] note_of(input logic [IDX_W-1:0] low);
      logic [IDX_W:0] raw;
      raw = {1'b0, low};
      if (raw >= (IDX_W+1)'(N_BTN)) begin
         raw = raw - (IDX_W+1)'(N_BTN);
      end else begin
         raw = raw;
      end
      note_of = raw[IDX_W-1:0];
   endfunction

   function automatic logic [N_BTN-1:0] onehot(input logic [IDX_W-1:0] idx);
      onehot = N_BTN'(1) << idx;
   endfunction

   function automatic logic [SCORE_W-1:0] sat_add(input logic [SCORE_W-1:0] a, input int pts);
      logic [SCORE_W:0] s;
      s = {1'b0, a} + (SCORE_W+1)'(pts);
      sat_add = s[SCORE_W] ? {SCORE_W{1'b1}} : s[SCORE_W-1:0];
   endfunction

   state_t             state_r, state_s;
   logic [15:0]        lfsr_r, seed_r, seed_s, replay_r, replay_s;
   logic               train_r, train_s, jogar_prev_r;
   logic [N_BTN-1:0]   botoes_prev_r;
   logic [TIM_W-1:0]   cyc_r, cyc_s;
   logic [CNT_W-1:0]   contagem_r, contagem_s, limite_r, limite_s;
   logic [SCORE_W-1:0] pontos_r, pontos_s;
   logic [2:0]         vidas_r, vidas_s;
   logic               timeout_s, timeout_r;
   logic [N_BTN-1:0]   leds_r, leds_s;
   logic               nota_valida_r, nota_valida_s;
   logic [IDX_W-1:0]   nota_idx_r, nota_idx_s;
   logic               pronto_r, pronto_s, acertou_r, acertou_s, errou_r, errou_s;

   logic jogar_edge_s, press_s, hit_s;
   assign jogar_edge_s = gif.jogar & ~jogar_prev_r;
   assign press_s      = (|gif.botoes) & ~(|botoes_prev_r);
   assign hit_s        = (gif.botoes == onehot(note_of(replay_r[IDX_W-1:0])));

   // State, datapath and output registers
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_r       <= INICIAL;
         lfsr_r        <= 16'hACE1;
         seed_r        <= 16'h0000;
         replay_r      <= 16'h0000;
         train_r       <= 1'b0;
         jogar_prev_r  <= 1'b0;
         botoes_prev_r <= '0;
         cyc_r         <= '0;
         contagem_r    <= '0;
         limite_r      <= '0;
         pontos_r      <= '0;
         vidas_r       <= 3'(LIVES);
         timeout_r     <= 1'b0;
         leds_r        <= '0;
         nota_valida_r <= 1'b0;
         nota_idx_r    <= '0;
         pronto_r      <= 1'b0;
         acertou_r     <= 1'b0;
         errou_r       <= 1'b0;
      end else begin
         state_r       <= state_s;
         lfsr_r        <= lfsr_step(lfsr_r);
         seed_r        <= seed_s;
         replay_r      <= replay_s;
         train_r       <= train_s;
         jogar_prev_r  <= gif.jogar;
         botoes_prev_r <= gif.botoes;
         cyc_r         <= cyc_s;
         contagem_r    <= contagem_s;
         limite_r      <= limite_s;
         pontos_r      <= pontos_s;
         vidas_r       <= vidas_s;
         timeout_r     <= timeout_s;
         leds_r        <= leds_s;
         nota_valida_r <= nota_valida_s;
         nota_idx_r    <= nota_idx_s;
         pronto_r      <= pronto_s;
         acertou_r     <= acertou_s;
         errou_r       <= errou_s;
      end
   end

   // Next state and datapath updates
   always_comb begin
      state_s    = state_r;
      seed_s     = seed_r;
      replay_s   = replay_r;
      train_s    = train_r;
      cyc_s      = cyc_r + TIM_W'(1);
      contagem_s = contagem_r;
      limite_s   = limite_r;
      pontos_s   = pontos_r;
      vidas_s    = vidas_r;
      timeout_s  = 1'b0;
      case (state_r)
         INICIAL, FIM_ACERTO, FIM_ERRO: begin
            cyc_s = '0;
            if (jogar_edge_s) begin
               state_s  = PREPARA;
               pontos_s = '0;
               vidas_s  = 3'(LIVES);
               limite_s = '0;
               seed_s   = lfsr_r;
               train_s  = gif.treinamento;
            end else begin
               state_s = state_r;
            end
         end
         PREPARA: begin
            contagem_s = '0;
            replay_s   = seed_r;
            cyc_s      = '0;
            state_s    = MOSTRA;
         end
         MOSTRA: begin
            if (cyc_r == TIM_W'(SHOW_CYC - 1)) begin
               cyc_s   = '0;
               state_s = INTERVALO;
            end else begin
               state_s = MOSTRA;
            end
         end
         INTERVALO: begin
            if (cyc_r == TIM_W'(GAP_CYC - 1)) begin
               cyc_s = '0;
               if (contagem_r < limite_r) begin
                  contagem_s = contagem_r + CNT_W'(1);
                  replay_s   = lfsr_step(replay_r);
                  state_s    = MOSTRA;
               end else begin
                  contagem_s = '0;
                  replay_s   = seed_r;
                  state_s    = ESPERA;
               end
            end else begin
               state_s = INTERVALO;
            end
         end
         ESPERA: begin
            // A press in the timeout cycle wins over the timeout
            if (press_s) begin
               if (hit_s) begin
                  pontos_s = train_r ? pontos_r : sat_add(pontos_r, HIT_PTS);
                  if (contagem_r < limite_r) begin
                     contagem_s = contagem_r + CNT_W'(1);
                     replay_s   = lfsr_step(replay_r);
                     cyc_s      = '0;
                     state_s    = ESPERA;
                  end else begin
                     state_s = PROXIMA;
                  end
               end else begin
                  state_s = ERRO_RODADA;
               end
            end else if (cyc_r == TIM_W'(TIMEOUT_CYC - 1)) begin
               timeout_s = 1'b1;
               state_s   = ERRO_RODADA;
            end else begin
               state_s = ESPERA;
            end
         end
         PROXIMA: begin
            pontos_s = train_r ? pontos_r : sat_add(pontos_r, ROUND_PTS);
            if (limite_r == CNT_W'(MAX_SEQ - 1)) begin
               state_s = FIM_ACERTO;
            end else begin
               limite_s = limite_r + CNT_W'(1);
               state_s  = PREPARA;
            end
         end
         ERRO_RODADA: begin
            if (train_r) begin
               state_s = PREPARA;
            end else begin
               vidas_s = vidas_r - 3'd1;
               state_s = (vidas_r == 3'd1) ? FIM_ERRO : PREPARA;
            end
         end
         default: begin
            state_s = INICIAL;
         end
      endcase
   end

   // Outputs decoded from the upcoming state so they register in step with it
   always_comb begin
      leds_s        = '0;
      nota_valida_s = 1'b0;
      nota_idx_s    = nota_idx_r;
      case (state_s)
         MOSTRA: begin
            leds_s        = onehot(note_of(replay_s[IDX_W-1:0]));
            nota_idx_s    = note_of(replay_s[IDX_W-1:0]);
            nota_valida_s = (state_r != MOSTRA);
         end
         ESPERA: begin
            leds_s = gif.botoes;
         end
         default: begin
            leds_s = '0;
         end
      endcase
      acertou_s = (state_s == FIM_ACERTO);
      errou_s   = (state_s == FIM_ERRO);
      pronto_s  = acertou_s | errou_s;
   end

   assign gif.leds        = leds_r;
   assign gif.pronto      = pronto_r;
   assign gif.acertou     = acertou_r;
   assign gif.errou       = errou_r;
   assign gif.nota_valida = nota_valida_r;
   assign gif.nota_idx    = nota_idx_r;
   assign gif.pontos      = pontos_r;
   assign gif.vidas       = vidas_r;
   assign gif.db_estado   = state_r;
   assign gif.db_limite   = limite_r;
   assign gif.db_contagem = contagem_r;
   assign gif.db_timeout  = timeout_r;
endmodule

// File: tb/tb_seq_game_core.sv
// Self-checking bench for seq_game_core: plays games against a model that derives
// notes from the cycle count since reset and scores from the game rules.
module tb_seq_game_core;
   localparam int N_BTN = 7, MAX_SEQ = 4, SHOW_CYC = 4, GAP_CYC = 2;
   localparam int TIMEOUT_CYC = 20, LIVES = 2, SCORE_W = 8;
   localparam int SCORE_MAX = (1 << SCORE_W) - 1;

   logic clock = 1'b0;
   logic reset = 1'b1;
   int   n_err = 0;
   int   n_chk = 0;
   int   n_cyc = 0;
   int   m_seed_n = 0;
   int   m_pontos = 0;
   int   m_vidas = LIVES;
   bit   m_train = 1'b0;

   seq_game_core_if #(.N_BTN(N_BTN), .MAX_SEQ(MAX_SEQ), .SCORE_W(SCORE_W)) gif ();

   seq_game_core #(
      .N_BTN(N_BTN), .MAX_SEQ(MAX_SEQ), .SHOW_CYC(SHOW_CYC), .GAP_CYC(GAP_CYC),
      .TIMEOUT_CYC(TIMEOUT_CYC), .LIVES(LIVES), .SCORE_W(SCORE_W)
   ) dut (
      .clock(clock),
      .reset(reset),
      .gif  (gif)
   );

   always #5 clock = ~clock;

   // Clock edges since reset release: the free-running LFSR has taken this many steps
   always @(posedge clock or posedge reset) begin
      if (reset) n_cyc <= 0;
      else       n_cyc <= n_cyc + 1;
   end

   initial begin
      #500000;
      $display("FAIL watchdog observed=timeout required=finish");
      $fatal(1);
   end

   function automatic logic [15:0] lfsr_after(input int n);
      logic [15:0] v = 16'hACE1;
      for (int i = 0; i < n; i++) v = v[0] ? ((v >> 1) ^ 16'hB400) : (v >> 1);
      return v;
   endfunction

   function automatic int note_at(input int k);
      logic [15:0] v = lfsr_after(m_seed_n + k);
      int r = int'(v[2:0]);
      if (r >= N_BTN) r = r - N_BTN;
      return r;
   endfunction

   function automatic logic [6:0] oh(input int i);
      logic [6:0] one = 7'd1;
      return one << i;
   endfunction

   function automatic int sat(input int v);
      return (v > SCORE_MAX) ? SCORE_MAX : v;
   endfunction

   task automatic tick();
      @(negedge clock);
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic start_game(input bit train);
      gif.treinamento = train;
      gif.jogar       = 1'b1;
      m_seed_n = n_cyc;
      m_train  = train;
      m_pontos = 0;
      m_vidas  = LIVES;
      tick();
      gif.jogar = 1'b0;
   endtask

   task automatic wait_state(input logic [4:0] code, input string tag);
      bit ok = 1'b0;
      for (int c = 0; c < 200; c++) begin
         if (gif.db_estado == code) begin ok = 1'b1; break; end
         tick();
      end
      chk({tag, "_reach"}, 32'(ok), 32'd1);
   endtask

   // Follow playback up to ESPERA, checking every announced note
   task automatic wait_espera(input int limite, input string tag);
      int seen = 0;
      bit ok = 1'b0;
      for (int c = 0; c < 300; c++) begin
         if (gif.nota_valida === 1'b1) begin
            chk({tag, "_nota_idx"}, 32'(gif.nota_idx), 32'(note_at(seen)));
            chk({tag, "_leds"}, 32'(gif.leds), 32'(oh(note_at(seen))));
            seen++;
         end
         if (gif.db_estado == 5'd4) begin ok = 1'b1; break; end
         tick();
      end
      chk({tag, "_espera"}, 32'(ok), 32'd1);
      chk({tag, "_n_notes"}, 32'(seen), 32'(limite + 1));
   endtask

   task automatic press(input logic [6:0] pat, input int hold);
      gif.botoes = pat;
      repeat (hold) tick();
      gif.botoes = '0;
      tick();
   endtask

   task automatic play_round(input int limite, input int first_delay, input string tag);
      wait_espera(limite, tag);
      for (int k = 0; k <= limite; k++) begin
         repeat ((k == 0) ? first_delay : $urandom_range(0, 4)) tick();
         press(oh(note_at(k)), (k == limite) ? 1 : $urandom_range(1, 3));
         if (!m_train) m_pontos = sat(m_pontos + 1);
      end
      if (!m_train) m_pontos = sat(m_pontos + 5);
      chk({tag, "_pontos"}, 32'(gif.pontos), 32'(m_pontos));
   endtask

   task automatic wait_timeout(input string tag, output int cnt);
      cnt = 0;
      while (gif.db_timeout !== 1'b1 && cnt < 60) begin
         tick();
         cnt++;
      end
      chk({tag, "_timeout_seen"}, 32'(gif.db_timeout), 32'd1);
   endtask

   initial begin
      int cnt;
      int n0;
      gif.jogar = 1'b0;
      gif.treinamento = 1'b0;
      gif.botoes = '0;
      repeat (3) tick();
      reset = 1'b0;
      chk("rst_estado", 32'(gif.db_estado), 32'd0);
      chk("rst_leds", 32'(gif.leds), 32'd0);
      chk("rst_pontos", 32'(gif.pontos), 32'd0);
      chk("rst_vidas", 32'(gif.vidas), 32'(LIVES));
      chk("rst_pronto", 32'(gif.pronto), 32'd0);
      repeat ($urandom_range(0, 50)) tick();

      // Full win in normal mode; round 0 answered in the last cycle before timeout
      start_game(1'b0);
      for (int r = 0; r < MAX_SEQ; r++) play_round(r, (r == 0) ? TIMEOUT_CYC - 1 : $urandom_range(0, 5), "win");
      chk("win_score30", 32'(gif.pontos), 32'd30);
      chk("win_acertou", 32'(gif.acertou), 32'd1);
      chk("win_pronto", 32'(gif.pronto), 32'd1);
      chk("win_errou", 32'(gif.errou), 32'd0);
      chk("win_estado", 32'(gif.db_estado), 32'd7);
      chk("win_vidas", 32'(gif.vidas), 32'(LIVES));
      repeat ($urandom_range(1, 20)) tick();

      // Timeout in round 0, same note replayed, start ignored mid-game, second timeout loses
      start_game(1'b0);
      wait_espera(0, "to");
      wait_timeout("to", cnt);
      chk("to_cycles", 32'(cnt), 32'(TIMEOUT_CYC));
      chk("to_estado", 32'(gif.db_estado), 32'd6);
      tick();
      m_vidas--;
      chk("to_pulse", 32'(gif.db_timeout), 32'd0);
      chk("to_vidas", 32'(gif.vidas), 32'(m_vidas));
      wait_espera(0, "to_replay");
      gif.jogar = 1'b1;
      tick();
      gif.jogar = 1'b0;
      chk("to_jogar_ign", 32'(gif.db_estado), 32'd4);
      wait_timeout("to2", cnt);
      tick();
      chk("to2_estado", 32'(gif.db_estado), 32'd8);
      chk("to2_errou", 32'(gif.errou), 32'd1);
      chk("to2_vidas", 32'(gif.vidas), 32'd0);
      repeat ($urandom_range(1, 20)) tick();

      // Two wrong presses
      start_game(1'b0);
      wait_espera(0, "wr");
      n0 = note_at(0);
      press(oh((n0 + 1 + $urandom_range(0, 5)) % N_BTN), 1);
      chk("wr_vidas1", 32'(gif.vidas), 32'd1);
      wait_espera(0, "wr_replay");
      press(oh((n0 + 1 + $urandom_range(0, 5)) % N_BTN), 1);
      chk("wr_vidas0", 32'(gif.vidas), 32'd0);
      chk("wr_errou", 32'(gif.errou), 32'd1);
      chk("wr_acertou", 32'(gif.acertou), 32'd0);
      chk("wr_estado", 32'(gif.db_estado), 32'd8);
      repeat ($urandom_range(1, 20)) tick();

      // Two-bit press is wrong; held button does not retrigger; reset mid-playback
      start_game(1'b0);
      wait_espera(0, "mb");
      n0 = note_at(0);
      press(oh(n0) | oh((n0 + 3) % N_BTN), 2);
      chk("mb_vidas", 32'(gif.vidas), 32'd1);
      chk("mb_pontos", 32'(gif.pontos), 32'd0);
      play_round(0, $urandom_range(0, 5), "mb_r0");
      wait_espera(1, "hold");
      gif.botoes = oh(note_at(0));
      repeat (4) tick();
      chk("hold_estado", 32'(gif.db_estado), 32'd4);
      chk("hold_contagem", 32'(gif.db_contagem), 32'd1);
      chk("hold_vidas", 32'(gif.vidas), 32'd1);
      gif.botoes = '0;
      tick();
      press(oh(note_at(1)), 1);
      m_pontos = sat(m_pontos + 1 + 1 + 5);
      chk("hold_pontos", 32'(gif.pontos), 32'(m_pontos));
      chk("hold_limite", 32'(gif.db_limite), 32'd2);
      wait_state(5'd2, "rst_mostra");
      chk("pre_rst_leds", 32'(gif.leds), 32'(oh(note_at(0))));
      #2 reset = 1'b1;
      #1;
      chk("async_estado", 32'(gif.db_estado), 32'd0);
      chk("async_leds", 32'(gif.leds), 32'd0);
      chk("async_pontos", 32'(gif.pontos), 32'd0);
      chk("async_vidas", 32'(gif.vidas), 32'(LIVES));
      tick();
      tick();
      reset = 1'b0;
      repeat ($urandom_range(1, 30)) tick();

      // Training: timeouts cost nothing, then a full win scores nothing
      start_game(1'b1);
      for (int i = 0; i < 3; i++) begin
         wait_espera(0, "tr");
         wait_timeout("tr", cnt);
         tick();
         chk("tr_estado", 32'(gif.db_estado), 32'd1);
         chk("tr_vidas", 32'(gif.vidas), 32'(LIVES));
         chk("tr_pontos", 32'(gif.pontos), 32'd0);
      end
      for (int r = 0; r < MAX_SEQ; r++) play_round(r, $urandom_range(0, 5), "tr_win");
      chk("tr_acertou", 32'(gif.acertou), 32'd1);
      chk("tr_final_pontos", 32'(gif.pontos), 32'd0);
      chk("tr_final_vidas", 32'(gif.vidas), 32'(LIVES));

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule
